// File: rtl/simmem_delay_releaser.sv
`default_nettype none
// -----------------------------------------------------------------------------
// simmem_delay_releaser : per-ID release enables after simulated request latency
// Rev 1.0
// -----------------------------------------------------------------------------
module simmem_delay_releaser #(
  parameter int IDWidth    = 2,
  parameter int NumSlots   = 8,
  parameter int DelayWidth = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [IDWidth-1:0]         req_id_i,
  input  logic [DelayWidth-1:0]      req_delay_i,
  output logic [(2**IDWidth)-1:0]    release_en_o,
  input  logic                       done_valid_i,
  input  logic [IDWidth-1:0]         done_id_i,
  output logic [$clog2(NumSlots):0]  occupancy_o
);

  localparam int RankW = $clog2(NumSlots);
  localparam int OccW  = RankW + 1;

  logic [NumSlots-1:0]   valid_q, valid_d;
  logic [IDWidth-1:0]    id_q   [NumSlots];
  logic [IDWidth-1:0]    id_d   [NumSlots];
  logic [DelayWidth-1:0] cnt_q  [NumSlots];
  logic [DelayWidth-1:0] cnt_d  [NumSlots];
  logic [RankW-1:0]      rank_q [NumSlots];
  logic [RankW-1:0]      rank_d [NumSlots];

  logic             alloc_found;
  logic [RankW-1:0] alloc_idx;
  logic [OccW-1:0]  same_cnt;
  logic [RankW-1:0] new_rank;
  logic             done_ok;
  logic             accept;

  // An ID is released when its head (rank 0) slot has fully counted down.
  always_comb begin
    release_en_o = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (valid_q[s] && (rank_q[s] == '0) && (cnt_q[s] == '0)) begin
        release_en_o[id_q[s]] = 1'b1;
      end
    end
  end

  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int s = NumSlots - 1; s >= 0; s--) begin
      if (!valid_q[s]) begin
        alloc_found = 1'b1;
        alloc_idx   = RankW'(s);
      end
    end
  end

  always_comb begin
    same_cnt = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (valid_q[s] && (id_q[s] == req_id_i)) begin
        same_cnt = same_cnt + OccW'(1);
      end
    end
  end

  assign req_ready_o = alloc_found;
  assign accept      = req_valid_i && alloc_found;
  // Completions for IDs that are not released are ignored.
  assign done_ok     = done_valid_i && release_en_o[done_id_i];
  assign new_rank    = (done_ok && (done_id_i == req_id_i)) ? RankW'(same_cnt - OccW'(1))
                                                             : RankW'(same_cnt);
  assign occupancy_o = OccW'($countones(valid_q));

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rank_d  = rank_q;
    for (int s = 0; s < NumSlots; s++) begin
      if (valid_q[s] && (cnt_q[s] != '0)) begin
        cnt_d[s] = cnt_q[s] - DelayWidth'(1);
      end
      if (done_ok && valid_q[s] && (id_q[s] == done_id_i)) begin
        if (rank_q[s] == '0) begin
          valid_d[s] = 1'b0;
        end else begin
          rank_d[s] = rank_q[s] - RankW'(1);
        end
      end
    end
    // Allocation targets a slot already free, so it never collides with a completion.
    if (accept) begin
      valid_d[alloc_idx] = 1'b1;
      id_d[alloc_idx]    = req_id_i;
      cnt_d[alloc_idx]   = req_delay_i;
      rank_d[alloc_idx]  = new_rank;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int s = 0; s < NumSlots; s++) begin
        id_q[s]   <= '0;
        cnt_q[s]  <= '0;
        rank_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < NumSlots; s++) begin
        id_q[s]   <= id_d[s];
        cnt_q[s]  <= cnt_d[s];
        rank_q[s] <= rank_d[s];
      end
    end
  end

  a_done_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    done_valid_i |-> release_en_o[done_id_i]);

endmodule
`default_nettype wire
